// File: rtl/mux_rr_select.sv
// Round-robin select/feed stage for a shared 2:1 mux datapath.
// Two valid/ready producers are arbitrated into one registered output slot;
// sel reports which producer the held word came from and drives the mux S bit.
module mux_rr_select #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  // The output slot is either empty or holding one word.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state_r;
  slot_state_t      state_nx_s;
  logic             prio_r;
  logic [WIDTH-1:0] out_data_r;
  logic             sel_r;

  logic             load_en_s;
  logic             grant_s;
  logic             grant_valid_s;
  logic             xfer_s;

  // Arbitration: single requester wins outright, ties go to the prio pointer.
  always_comb begin
    grant_s       = 1'b0;
    grant_valid_s = 1'b0;
    case ({in1_valid, in0_valid})
      2'b01: begin
        grant_s       = 1'b0;
        grant_valid_s = 1'b1;
      end
      2'b10: begin
        grant_s       = 1'b1;
        grant_valid_s = 1'b1;
      end
      2'b11: begin
        grant_s       = prio_r;
        grant_valid_s = 1'b1;
      end
      default: begin
        grant_s       = 1'b0;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // Slot can take a new word when empty or when its word leaves this cycle,
  // which gives back-to-back transfers without a bubble.
  always_comb begin
    load_en_s = (state_r == SLOT_EMPTY) | out_ready;
    xfer_s    = rst_n & load_en_s & grant_valid_s;
    in0_ready = xfer_s & (grant_s == 1'b0) & in0_valid;
    in1_ready = xfer_s & (grant_s == 1'b1) & in1_valid;
  end

  // Next slot state: load fills, drain without load empties, stall holds.
  always_comb begin
    state_nx_s = state_r;
    if (load_en_s && grant_valid_s) begin
      state_nx_s = SLOT_FULL;
    end else if (load_en_s) begin
      state_nx_s = SLOT_EMPTY;
    end else begin
      state_nx_s = state_r;
    end
  end

  // Slot state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= SLOT_EMPTY;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Captured word, its source and the round-robin pointer; a drain keeps
  // data and sel so the mux select does not glitch while the slot is empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_r <= {WIDTH{1'b0}};
      sel_r      <= 1'b0;
      prio_r     <= 1'b0;
    end else if (load_en_s && grant_valid_s) begin
      out_data_r <= grant_s ? in1_data : in0_data;
      sel_r      <= grant_s;
      prio_r     <= ~grant_s;
    end else begin
      out_data_r <= out_data_r;
      sel_r      <= sel_r;
      prio_r     <= prio_r;
    end
  end

  assign out_valid = (state_r == SLOT_FULL);
  assign out_data  = out_data_r;
  assign sel       = sel_r;

endmodule

// File: tb/tb_mux_rr_select.sv
// Directed bench for mux_rr_select: a vector table covering reset, single
// source, ties, backpressure and reset during a stall, then a streaming run.
module tb_mux_rr_select;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in0_valid;
  logic [WIDTH-1:0] in0_data;
  logic             in0_ready;
  logic             in1_valid;
  logic [WIDTH-1:0] in1_data;
  logic             in1_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             sel;

  int n_vectors;
  int n_checks;
  int n_miscompares;

  // One cycle of stimulus: inputs, readies expected this cycle, and
  // output slot contents expected after the following rising edge.
  typedef struct {
    logic             rst_n;
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             out_ready;
    logic             exp_in0_ready;
    logic             exp_in1_ready;
    logic             exp_out_valid;
    logic [WIDTH-1:0] exp_out_data;
    logic             exp_sel;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  mux_rr_select #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic ordy,
                              input logic er0, input logic er1, input logic eov,
                              input logic [7:0] ed, input logic es);
    vec_t v;
    v.rst_n = r;          v.in0_valid = v0;     v.in0_data = d0;
    v.in1_valid = v1;     v.in1_data = d1;      v.out_ready = ordy;
    v.exp_in0_ready = er0; v.exp_in1_ready = er1;
    v.exp_out_valid = eov; v.exp_out_data = ed; v.exp_sel = es;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    n_vectors = 0;
    n_checks = 0;
    n_miscompares = 0;
    rst_n = 1'b0; in0_valid = 1'b0; in0_data = 8'h00;
    in1_valid = 1'b0; in1_data = 8'h00; out_ready = 1'b0;

    //            rst  v0    d0     v1    d1     ordy  r0    r1    ov    data   sel
    // reset held two cycles with in0 requesting
    vecs[0]  = mk(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    // single source then drain
    vecs[2]  = mk(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
    // reset to clear prio, then ties alternate 11,22,11,22
    vecs[4]  = mk(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    vecs[6]  = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
    vecs[7]  = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    vecs[8]  = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
    // load 11, stall 3 cycles, release: next word from in1
    vecs[9]  = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    vecs[11] = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    vecs[12] = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
    vecs[13] = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 1'b1);
    // stall holding 22 (prio=0 afterwards would favour in0 anyway, so load
    // with prio=1 first is not needed), reset mid-stall, first grant to in0
    vecs[14] = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b1);
    vecs[15] = mk(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    vecs[16] = mk(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);

    @(posedge clk);
    #1;
    for (int i = 0; i < NVEC; i++) begin
      rst_n     = vecs[i].rst_n;
      in0_valid = vecs[i].in0_valid;
      in0_data  = vecs[i].in0_data;
      in1_valid = vecs[i].in1_valid;
      in1_data  = vecs[i].in1_data;
      out_ready = vecs[i].out_ready;
      n_vectors++;
      #1;
      check($sformatf("v%0d in0_ready", i), {31'b0, in0_ready}, {31'b0, vecs[i].exp_in0_ready});
      check($sformatf("v%0d in1_ready", i), {31'b0, in1_ready}, {31'b0, vecs[i].exp_in1_ready});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_out_valid});
      check($sformatf("v%0d out_data", i), {24'b0, out_data}, {24'b0, vecs[i].exp_out_data});
      check($sformatf("v%0d sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
    end

    // Streaming from in1 alone while the slot is full: every cycle must
    // accept and present the word on the next cycle with no gaps.
    in0_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in1_valid = 1'b1;
      in1_data  = 8'(k);
      n_vectors++;
      #1;
      check($sformatf("stream%0d in1_ready", k), {31'b0, in1_ready}, 32'd1);
      check($sformatf("stream%0d in0_ready", k), {31'b0, in0_ready}, 32'd0);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d out_valid", k), {31'b0, out_valid}, 32'd1);
      check($sformatf("stream%0d out_data", k), {24'b0, out_data}, k);
      check($sformatf("stream%0d sel", k), {31'b0, sel}, 32'd1);
    end

    // Drain only: valid falls, data and sel keep the last word.
    in1_valid = 1'b0;
    n_vectors++;
    @(posedge clk);
    #1;
    check("drain out_valid", {31'b0, out_valid}, 32'd0);
    check("drain out_data", {24'b0, out_data}, 32'h0F);
    check("drain sel", {31'b0, sel}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
